alu_issuer: RTL and testbench
=============================

# alu_issuer

Execute-stage sequencer sitting between decode and the `alu` responder in the core. Accepts one decoded instruction plus its operand pair over a valid/ready handshake, issues it to the ALU with a single-cycle `enabled` pulse, and waits for `completed`. It then captures `result`, resolves control flow (branch taken, next PC) and holds the response for write-back until accepted.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of WAIT cycles before the timeout response is forced. Only used with `ALU_ISSUE_TIMEOUT_EN`; legal range 1..255.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  decode offers an instruction.
- `req_ready`  out  1  issuer can accept; high only in IDLE.
- `req_instr`  in  `instructions`  decoded instruction, including `pc`, `imm` and the one-hot op flags.
- `req_register`  in  `regvpair`  operand values `rs1` and `rs2`.
- `alu_enabled`  out  1  issue pulse to the ALU.
- `alu_instr`  out  `instructions`  latched instruction; stable from ISSUE through WAIT.
- `alu_register`  out  `regvpair`  latched operands; stable from ISSUE through WAIT.
- `alu_completed`  in  1  ALU done.
- `alu_result`  in  32  ALU result.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  write-back accepts.
- `resp_result`  out  32  value to be written to rd.
- `resp_branch_taken`  out  1  control transfer taken.
- `resp_next_pc`  out  32  PC of the next instruction.
- `resp_timeout`  out  1  response was produced by timeout, not by the ALU.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch instr and register, go to ISSUE.
- ISSUE:
  - `alu_enabled`=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT:
  - On `alu_completed`: capture `alu_result` and the derived fields, go to HOLD.
  - Otherwise increment the wait counter (timeout build only).
- HOLD:
  - `resp_valid`=1; all `resp_*` outputs held stable.
  - On `resp_ready`: go to IDLE.
- `alu_completed` is ignored outside WAIT.
- Control resolution (all adds mod 2^32):
  - beq/bne/blt/bge/bltu/bgeu: taken = `alu_result[0]`. next_pc = pc+imm if taken, else pc+4. resp_result = `alu_result`.
  - jal: taken=1, next_pc = pc+imm.
  - jalr: taken=1, next_pc = (rs1+imm) & 32'hFFFF_FFFE.
  - All other ops: taken=0, next_pc = pc+4.
- Reset:
  - State IDLE.
  - `req_ready`=1 while `rst`=0.
  - `alu_enabled`, `resp_valid`, `resp_branch_taken` and `resp_timeout` = 0.
  - `resp_result`, `resp_next_pc`, `alu_instr` and `alu_register` = 0.
- Reset mid-operation: asynchronous abort from any state. `alu_enabled` and `resp_valid` drop immediately; the in-flight instruction is discarded.

## Timing
- Request accepted at edge E0 → ISSUE during cycle 1 → `alu_completed` seen in cycle 2 (with a one-cycle ALU) → `resp_valid` from cycle 3.
- Minimum occupancy 4 cycles per instruction when `resp_ready` is tied high; no overlap between instructions.
- `alu_enabled` is never high for more than one consecutive cycle.
- `alu_instr` and `alu_register` change only on acceptance in IDLE.
- `resp_*` outputs change only on the WAIT→HOLD transition or on reset.

## Configuration
- `ALU_ISSUE_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in WAIT.
  - When the counter reaches `TIMEOUT_CYCLES` with no `alu_completed`, go to HOLD with `resp_result`=0, `resp_branch_taken`=0, `resp_next_pc`=pc+4 and `resp_timeout`=1.
  - If `alu_completed` arrives in the same cycle the limit is hit, `alu_completed` wins and `resp_timeout`=0.
- `ALU_ISSUE_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts indefinitely.
  - `resp_timeout` is tied to 0.

## Test plan
- addi, pc=0x100, rs1=5, imm=7; ALU returns 12 → `alu_enabled` high 1 cycle; `resp_result`=12, `resp_next_pc`=0x104, taken=0, `resp_valid` at cycle 3.
- beq, pc=0x200, imm=0x40; ALU returns 1 → taken=1, next_pc=0x240. Same with ALU result 0 → taken=0, next_pc=0x204.
- jalr, pc=0x300, rs1=0x1003, imm=4; ALU returns 0x304 → next_pc=0x1006, `resp_result`=0x304, taken=1.
- `resp_ready` held low 5 cycles in HOLD, `req_valid` high throughout → `req_ready`=0, outputs stable, no second `alu_enabled`; accept occurs the cycle after the HOLD→IDLE transition.
- Timeout build, `TIMEOUT_CYCLES`=4, ALU never completes → `resp_timeout`=1, `resp_result`=0, next_pc=pc+4. Late `alu_completed` in HOLD is ignored.
- Assert `rst` mid-WAIT → `alu_enabled`/`resp_valid`=0 immediately, state IDLE, `req_ready`=1 after release; a subsequent addi completes normally.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: execute-stage sequencer that issues one decoded instruction to the ALU and holds its response.
// Optional wait timeout is compiled in when ALU_ISSUE_TIMEOUT_EN is defined.
package alu_issuer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic op_add, op_sub, op_addi, op_and, op_or, op_xor, op_lui;
    logic op_beq, op_bne, op_blt, op_bge, op_bltu, op_bgeu, op_jal, op_jalr;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

endpackage

module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  instructions req_instr,
  input  regvpair     req_register,
  output logic        alu_enabled,
  output instructions alu_instr,
  output regvpair     alu_register,
  input  logic        alu_completed,
  input  logic [31:0] alu_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_branch_taken,
  output logic [31:0] resp_next_pc,
  output logic        resp_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        capture_alu;
  logic        capture_timeout;
  logic        is_branch;
  logic        taken_calc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_target;
  logic [31:0] next_pc_calc;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt_reg;
`endif

  always_comb begin
    state_next      = state_reg;
    capture_alu     = 1'b0;
    capture_timeout = 1'b0;
    case (state_reg)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (alu_completed) begin
          capture_alu = 1'b1;
          state_next  = HOLD;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (wait_cnt_reg == TIMEOUT_LIMIT) begin
          capture_timeout = 1'b1;
          state_next      = HOLD;
        end
`endif
      end
      HOLD:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = (state_reg == IDLE) && !rst;
  assign alu_enabled = (state_reg == ISSUE);
  assign resp_valid  = (state_reg == HOLD);

  // Control resolution works off the latched instruction, which is stable through WAIT.
  assign is_branch   = alu_instr.op_beq | alu_instr.op_bne | alu_instr.op_blt |
                       alu_instr.op_bge | alu_instr.op_bltu | alu_instr.op_bgeu;
  assign pc_plus4    = alu_instr.pc + 32'd4;
  assign pc_plus_imm = alu_instr.pc + alu_instr.imm;
  assign jalr_target = (alu_register.rs1 + alu_instr.imm) & 32'hFFFF_FFFE;

  always_comb begin
    taken_calc   = 1'b0;
    next_pc_calc = pc_plus4;
    if (is_branch) begin
      taken_calc   = alu_result[0];
      next_pc_calc = alu_result[0] ? pc_plus_imm : pc_plus4;
    end else if (alu_instr.op_jal) begin
      taken_calc   = 1'b1;
      next_pc_calc = pc_plus_imm;
    end else if (alu_instr.op_jalr) begin
      taken_calc   = 1'b1;
      next_pc_calc = jalr_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      alu_instr    <= '0;
      alu_register <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        alu_instr    <= req_instr;
        alu_register <= req_register;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result       <= '0;
      resp_branch_taken <= 1'b0;
      resp_next_pc      <= '0;
    end else if (capture_alu) begin
      resp_result       <= alu_result;
      resp_branch_taken <= taken_calc;
      resp_next_pc      <= next_pc_calc;
    end else if (capture_timeout) begin
      resp_result       <= '0;
      resp_branch_taken <= 1'b0;
      resp_next_pc      <= pc_plus4;
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      resp_timeout <= 1'b0;
    end else begin
      if (state_reg == ISSUE)
        wait_cnt_reg <= '0;
      else if (state_reg == WAIT && !alu_completed)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (capture_alu)
        resp_timeout <= 1'b0;
      else if (capture_timeout)
        resp_timeout <= 1'b1;
    end
  end
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: directed test-plan cases plus randomized transactions against a reference model.
`timescale 1ns/1ps
module tb_alu_issuer;
  import alu_issuer_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  instructions req_instr;
  regvpair     req_register;
  logic        alu_enabled;
  instructions alu_instr;
  regvpair     alu_register;
  logic        alu_completed;
  logic [31:0] alu_result;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_branch_taken;
  logic [31:0] resp_next_pc;
  logic        resp_timeout;

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;

  always #5 clk = ~clk;

  alu_issuer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_register(req_register),
    .alu_enabled(alu_enabled), .alu_instr(alu_instr), .alu_register(alu_register),
    .alu_completed(alu_completed), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_branch_taken(resp_branch_taken),
    .resp_next_pc(resp_next_pc), .resp_timeout(resp_timeout)
  );

  // Issue-pulse monitor: counts pulses and flags back-to-back enables.
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_enabled === 1'b1) begin
        en_pulses++;
        checks++;
        if (prev_en === 1'b1) begin
          errors++;
          $display("FAIL enable_single_cycle: got enabled in consecutive cycles, required one cycle");
        end
      end
      prev_en = alu_enabled;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // op index: 0 add,1 sub,2 addi,3 and,4 or,5 xor,6 lui,7..12 branches,13 jal,14 jalr
  function automatic instructions make_instr(input int op, input logic [31:0] pc, input logic [31:0] imm);
    instructions i;
    i = '0;
    i.pc  = pc;
    i.imm = imm;
    i.rd  = 5'd1;
    case (op)
      0: i.op_add = 1'b1;   1: i.op_sub = 1'b1;   2: i.op_addi = 1'b1;
      3: i.op_and = 1'b1;   4: i.op_or = 1'b1;    5: i.op_xor = 1'b1;
      6: i.op_lui = 1'b1;   7: i.op_beq = 1'b1;   8: i.op_bne = 1'b1;
      9: i.op_blt = 1'b1;   10: i.op_bge = 1'b1;  11: i.op_bltu = 1'b1;
      12: i.op_bgeu = 1'b1; 13: i.op_jal = 1'b1;  14: i.op_jalr = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  function automatic void model(input int op, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] alu_res,
                                output logic [31:0] res, output logic [31:0] npc, output logic tk);
    res = alu_res;
    if (op >= 7 && op <= 12) begin
      tk  = alu_res[0];
      npc = tk ? pc + imm : pc + 32'd4;
    end else if (op == 13) begin
      tk  = 1'b1;
      npc = pc + imm;
    end else if (op == 14) begin
      tk  = 1'b1;
      npc = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      tk  = 1'b0;
      npc = pc + 32'd4;
    end
  endfunction

  // Starts at a negedge in IDLE, ends at the negedge after HOLD->IDLE.
  task automatic do_txn(input string name, input int op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] res,
                        input int lat, input int hold, input bit keep_valid);
    instructions ins;
    regvpair     rp;
    logic [31:0] e_res, e_npc;
    logic        e_tk;
    int          p0;
    ins = make_instr(op, pc, imm);
    rp.rs1 = rs1;
    rp.rs2 = rs2;
    model(op, pc, imm, rs1, res, e_res, e_npc, e_tk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s.req_ready_idle: got %b required 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_instr = ins;
    req_register = rp;
    p0 = en_pulses;
    @(negedge clk);
    if (keep_valid) req_instr = make_instr(2, pc + 32'd4, 32'd7);
    else req_valid = 1'b0;
    checks++;
    if (alu_enabled !== 1'b1 || alu_instr !== ins || alu_register !== rp) begin
      errors++;
      $display("FAIL %s.issue: got en=%b instr=%h regs=%h required en=1 instr=%h regs=%h",
               name, alu_enabled, alu_instr, alu_register, ins, rp);
    end
    for (int w = 0; w <= lat; w++) begin
      @(negedge clk);
      checks++;
      if (alu_enabled !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s.wait: got en=%b resp_valid=%b required 0/0", name, alu_enabled, resp_valid);
      end
      alu_result = $urandom;
      if (w == lat) begin
        alu_completed = 1'b1;
        alu_result = res;
      end
    end
    @(negedge clk);
    alu_completed = 1'b0;
    alu_result = $urandom;
    for (int k = 0; k <= hold; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== e_res || resp_next_pc !== e_npc ||
          resp_branch_taken !== e_tk || resp_timeout !== 1'b0) begin
        errors++;
        $display("FAIL %s.resp[%0d]: got v=%b res=%h npc=%h tk=%b to=%b required v=1 res=%h npc=%h tk=%b to=0",
                 name, k, resp_valid, resp_result, resp_next_pc, resp_branch_taken, resp_timeout,
                 e_res, e_npc, e_tk);
      end
      checks++;
      if (req_ready !== 1'b0 || alu_enabled !== 1'b0 || alu_instr !== ins) begin
        errors++;
        $display("FAIL %s.hold_block[%0d]: got req_ready=%b en=%b instr=%h required 0/0/%h",
                 name, k, req_ready, alu_enabled, alu_instr, ins);
      end
      resp_ready = (k == hold);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s.back_to_idle: got resp_valid=%b req_ready=%b required 0/1", name, resp_valid, req_ready);
    end
    checks++;
    if (en_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL %s.pulse_count: got %0d required 1", name, en_pulses - p0);
    end
    $display("txn %s op=%0d pc=%h res=%h npc=%h tk=%b", name, op, pc, e_res, e_npc, e_tk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_instr = '0;
    req_register = '0;
    alu_completed = 1'b0;
    alu_result = '0;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (alu_enabled !== 1'b0 || resp_valid !== 1'b0 || resp_branch_taken !== 1'b0 || resp_timeout !== 1'b0 ||
        resp_result !== 32'd0 || resp_next_pc !== 32'd0 || alu_instr !== '0 || alu_register !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%b v=%b tk=%b to=%b res=%h npc=%h required all zero",
               alu_enabled, resp_valid, resp_branch_taken, resp_timeout, resp_result, resp_next_pc);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_directed;
    do_txn("addi",      2,  32'h100, 32'd7,    32'd5,      32'd0, 32'd12,   0, 0, 1'b0);
    do_txn("beq_taken", 7,  32'h200, 32'h40,   32'd3,      32'd3, 32'd1,    0, 0, 1'b0);
    do_txn("beq_not",   7,  32'h200, 32'h40,   32'd3,      32'd4, 32'd0,    1, 0, 1'b0);
    do_txn("jalr",      14, 32'h300, 32'd4,    32'h1003,   32'd0, 32'h304,  0, 0, 1'b0);
    do_txn("jal",       13, 32'h400, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h404,  2, 1, 1'b0);
`ifndef ALU_ISSUE_TIMEOUT_EN
    do_txn("slow_alu",  0,  32'h500, 32'd0,    32'd1,      32'd2, 32'd3,   20, 0, 1'b0);
`endif
  endtask

  task automatic test_backpressure;
    instructions ins2;
    ins2 = make_instr(2, 32'h604, 32'd7);
    do_txn("backpressure", 2, 32'h600, 32'h10, 32'h20, 32'd0, 32'h30, 0, 5, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_enabled !== 1'b1 || alu_instr !== ins2) begin
      errors++;
      $display("FAIL bp_second_accept: got en=%b instr=%h required en=1 instr=%h", alu_enabled, alu_instr, ins2);
    end
    req_valid = 1'b0;
    @(negedge clk);
    alu_completed = 1'b1;
    alu_result = 32'h55;
    @(negedge clk);
    alu_completed = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'h55 || resp_next_pc !== 32'h608) begin
      errors++;
      $display("FAIL bp_second_resp: got v=%b res=%h npc=%h required 1/00000055/00000608",
               resp_valid, resp_result, resp_next_pc);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn backpressure second done");
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1;
    req_instr = make_instr(2, 32'h700, 32'd7);
    req_register.rs1 = 32'd9;
    req_register.rs2 = 32'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_enabled !== 1'b0 || resp_valid !== 1'b0 || alu_instr !== '0 || alu_register !== '0 ||
        resp_result !== 32'd0 || resp_next_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: got en=%b v=%b instr=%h res=%h npc=%h required zeros",
               alu_enabled, resp_valid, alu_instr, resp_result, resp_next_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b required 1", req_ready);
    end
    do_txn("after_reset", 2, 32'h100, 32'd7, 32'd5, 32'd0, 32'd12, 0, 0, 1'b0);
    // abort while the response is being held
    req_valid = 1'b1;
    req_instr = make_instr(13, 32'h800, 32'h20);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    alu_completed = 1'b1;
    alu_result = 32'h804;
    @(negedge clk);
    alu_completed = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 32'd0 || resp_branch_taken !== 1'b0 || resp_next_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_hold: got v=%b res=%h tk=%b npc=%h required zeros",
               resp_valid, resp_result, resp_branch_taken, resp_next_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset mid-operation done");
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      int op;
      op = int'($urandom_range(0, 14));
      do_txn($sformatf("rand%0d", n), op, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, $urandom,
             $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

`ifdef ALU_ISSUE_TIMEOUT_EN
  task automatic test_timeout;
    bit found;
    found = 1'b0;
    req_valid = 1'b1;
    req_instr = make_instr(7, 32'h900, 32'h40);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_reached: got no response within 64 cycles, required timeout response");
    end
    checks++;
    if (resp_timeout !== 1'b1 || resp_result !== 32'd0 || resp_branch_taken !== 1'b0 || resp_next_pc !== 32'h904) begin
      errors++;
      $display("FAIL timeout_resp: got to=%b res=%h tk=%b npc=%h required 1/0/0/00000904",
               resp_timeout, resp_result, resp_branch_taken, resp_next_pc);
    end
    alu_completed = 1'b1;
    alu_result = 32'h0000_dead;
    repeat (2) @(negedge clk);
    alu_completed = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_timeout !== 1'b1 || resp_result !== 32'd0 || resp_next_pc !== 32'h904) begin
      errors++;
      $display("FAIL timeout_late_complete: got v=%b to=%b res=%h npc=%h required 1/1/0/00000904",
               resp_valid, resp_timeout, resp_result, resp_next_pc);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
